// File: rtl/perceptron_bp.sv
// perceptron_bp: backward-pass weight/bias update for a single perceptron.
// Q8.24 signed fixed point. The lr*delta product is computed once, then one
// element per cycle updates a weight and produces the back-propagated error.
// Optional build macro: PERCEPTRON_BP_SAT_EN saturates every multiply and
// subtract result. When it is undefined, results wrap in two's complement.
module perceptron_bp #(
    parameter int unsigned NUM   = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [NUM*WIDTH-1:0] i_k,
    input  logic [NUM*WIDTH-1:0] i_w,
    input  logic [WIDTH-1:0]     i_b,
    input  logic [WIDTH-1:0]     i_delta,
    input  logic [WIDTH-1:0]     i_lr,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [NUM*WIDTH-1:0] o_w,
    output logic [WIDTH-1:0]     o_b,
    output logic [NUM*WIDTH-1:0] o_dk
);

    localparam int unsigned FRAC = 24;
    localparam int unsigned IDXW = (NUM > 1) ? $clog2(NUM) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StScale,
        StElem,
        StBias,
        StDone
    } state_e;

    state_e                    state_q, state_d;
    logic [IDXW-1:0]           idx_q, idx_d;
    logic [NUM-1:0][WIDTH-1:0] k_q, k_d;
    logic [NUM-1:0][WIDTH-1:0] w_q, w_d;
    logic [NUM-1:0][WIDTH-1:0] o_w_q, o_w_d;
    logic [NUM-1:0][WIDTH-1:0] o_dk_q, o_dk_d;
    logic [WIDTH-1:0]          b_q, b_d;
    logic [WIDTH-1:0]          delta_q, delta_d;
    logic [WIDTH-1:0]          lr_q, lr_d;
    logic [WIDTH-1:0]          ld_q, ld_d;
    logic [WIDTH-1:0]          o_b_q, o_b_d;
    logic                      o_valid_q, o_valid_d;
    logic                      o_ready_q, o_ready_d;

    // Fixed-point multiply: full product, floor shift by FRAC, keep WIDTH bits.
    function automatic logic [WIDTH-1:0] fxmul(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] prod;
        logic [WIDTH-1:0]          res;
        prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        prod = prod >>> FRAC;
        res  = prod[WIDTH-1:0];
`ifdef PERCEPTRON_BP_SAT_EN
        // Upper bits not a pure sign extension means the value left the range.
        if (prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod[2*WIDTH-1]}}) begin
            res = prod[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        return res;
    endfunction

    // Fixed-point subtract a - b.
    function automatic logic [WIDTH-1:0] fxsub(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
`ifdef PERCEPTRON_BP_SAT_EN
        logic [WIDTH:0]   diff;
        logic [WIDTH-1:0] res;
        diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        res  = diff[WIDTH-1:0];
        if (diff[WIDTH] != diff[WIDTH-1]) begin
            res = diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        return res;
`else
        return a - b;
`endif
    endfunction

    // Next-state and datapath: everything holds unless the current state updates it.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        k_d       = k_q;
        w_d       = w_q;
        b_d       = b_q;
        delta_d   = delta_q;
        lr_d      = lr_q;
        ld_d      = ld_q;
        o_w_d     = o_w_q;
        o_dk_d    = o_dk_q;
        o_b_d     = o_b_q;
        o_valid_d = o_valid_q;
        o_ready_d = o_ready_q;

        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    k_d       = i_k;
                    w_d       = i_w;
                    b_d       = i_b;
                    delta_d   = i_delta;
                    lr_d      = i_lr;
                    o_ready_d = 1'b0;
                    state_d   = StScale;
                end
            end
            StScale: begin
                ld_d    = fxmul(lr_q, delta_q);
                idx_d   = '0;
                state_d = StElem;
            end
            StElem: begin
                // Error propagates through the old weight, not the updated one.
                o_w_d[idx_q]  = fxsub(w_q[idx_q], fxmul(ld_q, k_q[idx_q]));
                o_dk_d[idx_q] = fxmul(delta_q, w_q[idx_q]);
                if (idx_q == IDXW'(NUM - 1)) begin
                    state_d = StBias;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StBias: begin
                o_b_d     = fxsub(b_q, ld_q);
                o_valid_d = 1'b1;
                state_d   = StDone;
            end
            StDone: begin
                if (i_ready) begin
                    o_valid_d = 1'b0;
                    o_ready_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d   = StIdle;
                o_valid_d = 1'b0;
                o_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset discards any update in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            k_q       <= '0;
            w_q       <= '0;
            b_q       <= '0;
            delta_q   <= '0;
            lr_q      <= '0;
            ld_q      <= '0;
            o_w_q     <= '0;
            o_dk_q    <= '0;
            o_b_q     <= '0;
            o_valid_q <= 1'b0;
            o_ready_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            k_q       <= k_d;
            w_q       <= w_d;
            b_q       <= b_d;
            delta_q   <= delta_d;
            lr_q      <= lr_d;
            ld_q      <= ld_d;
            o_w_q     <= o_w_d;
            o_dk_q    <= o_dk_d;
            o_b_q     <= o_b_d;
            o_valid_q <= o_valid_d;
            o_ready_q <= o_ready_d;
        end
    end

    assign o_ready = o_ready_q;
    assign o_valid = o_valid_q;
    assign o_w     = o_w_q;
    assign o_dk    = o_dk_q;
    assign o_b     = o_b_q;

endmodule

// File: tb/tb_perceptron_bp.sv
// Testbench for perceptron_bp (NUM=2, Q8.24). Honours PERCEPTRON_BP_SAT_EN
// in its reference model and in the overflow vector.
module tb_perceptron_bp;

    localparam int unsigned NUM   = 2;
    localparam int unsigned WIDTH = 32;
`ifdef PERCEPTRON_BP_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                 clk;
    logic                 rst;
    logic                 i_valid;
    logic                 o_ready;
    logic [NUM*WIDTH-1:0] i_k;
    logic [NUM*WIDTH-1:0] i_w;
    logic [WIDTH-1:0]     i_b;
    logic [WIDTH-1:0]     i_delta;
    logic [WIDTH-1:0]     i_lr;
    logic                 o_valid;
    logic                 i_ready;
    logic [NUM*WIDTH-1:0] o_w;
    logic [WIDTH-1:0]     o_b;
    logic [NUM*WIDTH-1:0] o_dk;

    int n_checks = 0;
    int n_errors = 0;

    perceptron_bp #(.NUM(NUM), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_k     (i_k),
        .i_w     (i_w),
        .i_b     (i_b),
        .i_delta (i_delta),
        .i_lr    (i_lr),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_w     (o_w),
        .o_b     (o_b),
        .o_dk    (o_dk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] k0, k1, w0, w1, b, delta, lr;
        logic [31:0] ew0, ew1, eb, edk0, edk1;
    } vec_t;

    // Reference arithmetic on real integers: value/2^24 floored, then clamp or wrap.
    function automatic logic [31:0] clamp32(input longint v);
        longint r;
        r = v;
        if (SAT) begin
            if (r > 64'sd2147483647) r = 64'sd2147483647;
            if (r < -64'sd2147483648) r = -64'sd2147483648;
        end
        return r[31:0];
    endfunction

    function automatic logic [31:0] m_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return clamp32(p >>> 24);
    endfunction

    function automatic logic [31:0] m_sub(input logic [31:0] a, input logic [31:0] b);
        return clamp32(longint'($signed(a)) - longint'($signed(b)));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One request; returns outputs at o_valid and edges-from-accept latency.
    task automatic do_req(input logic [31:0] k0, k1, w0, w1, b, d, lr,
                          input bit scramble, input bit ack,
                          output logic [31:0] rw0, rw1, rb, rdk0, rdk1,
                          output int lat);
        @(negedge clk);
        i_k = {k1, k0}; i_w = {w1, w0}; i_b = b; i_delta = d; i_lr = lr;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        if (scramble) begin
            i_k = {$urandom, $urandom}; i_w = {$urandom, $urandom};
            i_b = $urandom; i_delta = $urandom; i_lr = $urandom;
        end
        chk("ready_drop", {31'd0, o_ready}, 32'd0);
        lat = 0;
        while (lat < 50) begin
            @(posedge clk); #1;
            lat++;
            if (o_valid) break;
        end
        rw0 = o_w[31:0]; rw1 = o_w[63:32]; rb = o_b;
        rdk0 = o_dk[31:0]; rdk1 = o_dk[63:32];
        if (ack) begin
            @(negedge clk); i_ready = 1'b1;
            @(posedge clk); #1; i_ready = 1'b0;
            chk("ack_valid_fall", {31'd0, o_valid}, 32'd0);
            chk("ack_ready_rise", {31'd0, o_ready}, 32'd1);
        end
    endtask

    task automatic cmp_res(input string nm, input logic [31:0] rw0, rw1, rb, rdk0, rdk1,
                           input logic [31:0] ew0, ew1, eb, edk0, edk1, input int lat);
        chk({nm, ".lat"}, lat, 32'd4);
        chk({nm, ".w0"}, rw0, ew0);
        chk({nm, ".w1"}, rw1, ew1);
        chk({nm, ".b"}, rb, eb);
        chk({nm, ".dk0"}, rdk0, edk0);
        chk({nm, ".dk1"}, rdk1, edk1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs [4];
        logic [31:0] rw0, rw1, rb, rdk0, rdk1;
        logic [31:0] k0, k1, w0, w1, b, d, lr, ld;
        int          lat;

        vecs[0] = '{"basic", 32'h01000000, 32'h02000000, 32'h00800000, 32'h00400000, 32'h0,
                    32'h01000000, 32'h00800000,
                    32'h00000000, 32'hFF400000, 32'hFF800000, 32'h00800000, 32'h00400000};
        vecs[1] = '{"overflow", 32'h02000000, 32'h0, 32'h0, 32'h0, 32'h0,
                    32'h7F000000, 32'h01000000,
                    SAT ? 32'h80000001 : 32'h02000000, 32'h0, 32'h81000000, 32'h0, 32'h0};
        vecs[2] = '{"negtrunc", 32'h01000000, 32'h0, 32'h01000000, 32'h0, 32'h00000010,
                    32'hFFFFFFFF, 32'h00800000,
                    32'h01000001, 32'h0, 32'h00000011, 32'hFFFFFFFF, 32'h0};
        vecs[3] = '{"zero", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                    32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

        rst = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_k = '0; i_w = '0; i_b = '0; i_delta = '0; i_lr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", {31'd0, o_ready}, 32'd1);
        chk("rst.valid", {31'd0, o_valid}, 32'd0);
        chk("rst.w", o_w[31:0] | o_w[63:32], 32'd0);
        chk("rst.b", o_b, 32'd0);
        chk("rst.dk", o_dk[31:0] | o_dk[63:32], 32'd0);
        @(negedge clk); rst = 1'b1;

        // Directed vectors
        for (int i = 0; i < 4; i++) begin
            do_req(vecs[i].k0, vecs[i].k1, vecs[i].w0, vecs[i].w1, vecs[i].b,
                   vecs[i].delta, vecs[i].lr, 1'b0, 1'b1, rw0, rw1, rb, rdk0, rdk1, lat);
            cmp_res(vecs[i].name, rw0, rw1, rb, rdk0, rdk1, vecs[i].ew0, vecs[i].ew1,
                    vecs[i].eb, vecs[i].edk0, vecs[i].edk1, lat);
        end

        // Input isolation: inputs scrambled right after the accepting edge
        do_req(vecs[0].k0, vecs[0].k1, vecs[0].w0, vecs[0].w1, vecs[0].b,
               vecs[0].delta, vecs[0].lr, 1'b1, 1'b1, rw0, rw1, rb, rdk0, rdk1, lat);
        cmp_res("isolate", rw0, rw1, rb, rdk0, rdk1, vecs[0].ew0, vecs[0].ew1,
                vecs[0].eb, vecs[0].edk0, vecs[0].edk1, lat);

        // Back-pressure: hold in DONE with competing requests on the input
        do_req(vecs[0].k0, vecs[0].k1, vecs[0].w0, vecs[0].w1, vecs[0].b,
               vecs[0].delta, vecs[0].lr, 1'b0, 1'b0, rw0, rw1, rb, rdk0, rdk1, lat);
        cmp_res("bp", rw0, rw1, rb, rdk0, rdk1, vecs[0].ew0, vecs[0].ew1,
                vecs[0].eb, vecs[0].edk0, vecs[0].edk1, lat);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            i_valid = 1'b1; i_k = {$urandom, $urandom}; i_w = {$urandom, $urandom};
            i_b = $urandom; i_delta = $urandom; i_lr = $urandom;
            @(posedge clk); #1;
            chk("bp.valid", {31'd0, o_valid}, 32'd1);
            chk("bp.ready", {31'd0, o_ready}, 32'd0);
            chk("bp.w1", o_w[63:32], vecs[0].ew1);
            chk("bp.b", o_b, vecs[0].eb);
            chk("bp.dk0", o_dk[31:0], vecs[0].edk0);
        end
        @(negedge clk); i_valid = 1'b0; i_ready = 1'b1;
        @(posedge clk); #1; i_ready = 1'b0;
        chk("bp.rel_ready", {31'd0, o_ready}, 32'd1);
        chk("bp.rel_valid", {31'd0, o_valid}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("bp.idle_valid", {31'd0, o_valid}, 32'd0);
        chk("bp.idle_hold_b", o_b, vecs[0].eb);

        // Reset during ELEM index 1
        @(negedge clk);
        i_k = {vecs[2].k1, vecs[2].k0}; i_w = {vecs[2].w1, vecs[2].w0};
        i_b = vecs[2].b; i_delta = vecs[2].delta; i_lr = vecs[2].lr; i_valid = 1'b1;
        @(posedge clk); #1; i_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mrst.valid", {31'd0, o_valid}, 32'd0);
        chk("mrst.ready", {31'd0, o_ready}, 32'd1);
        chk("mrst.w", o_w[31:0] | o_w[63:32], 32'd0);
        chk("mrst.b", o_b, 32'd0);
        chk("mrst.dk", o_dk[31:0] | o_dk[63:32], 32'd0);
        @(negedge clk); rst = 1'b1;
        do_req(vecs[0].k0, vecs[0].k1, vecs[0].w0, vecs[0].w1, vecs[0].b,
               vecs[0].delta, vecs[0].lr, 1'b0, 1'b1, rw0, rw1, rb, rdk0, rdk1, lat);
        cmp_res("after_rst", rw0, rw1, rb, rdk0, rdk1, vecs[0].ew0, vecs[0].ew1,
                vecs[0].eb, vecs[0].edk0, vecs[0].edk1, lat);

        // Random samples against the reference model
        for (int r = 0; r < 40; r++) begin
            k0 = $urandom; k1 = $urandom; w0 = $urandom; w1 = $urandom;
            b = $urandom; d = $urandom; lr = $urandom;
            if (r % 2 == 0) begin
                // Small magnitudes keep half the samples away from overflow
                k0 = 32'($signed(k0) >>> 6); k1 = 32'($signed(k1) >>> 6);
                w0 = 32'($signed(w0) >>> 6); w1 = 32'($signed(w1) >>> 6);
                d  = 32'($signed(d) >>> 6);  lr = 32'($signed(lr) >>> 8);
            end
            do_req(k0, k1, w0, w1, b, d, lr, r[0], 1'b1, rw0, rw1, rb, rdk0, rdk1, lat);
            ld = m_mul(lr, d);
            cmp_res("rand", rw0, rw1, rb, rdk0, rdk1,
                    m_sub(w0, m_mul(ld, k0)), m_sub(w1, m_mul(ld, k1)), m_sub(b, ld),
                    m_mul(d, w0), m_mul(d, w1), lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/perceptron_bp.md
Name: perceptron_bp

Overview:
Backward-pass (training) companion to the forward perceptron. It accepts one training sample: inputs, current weights, bias, the neuron's error term delta, and a learning rate. It returns updated weights and bias, plus the error propagated back to each input (delta*w_i) for the previous layer. All values are Q8.24 signed fixed point (8-bit signed integer, 24-bit fraction). A single shared lr*delta product feeds a sequential per-element update loop, one element per cycle.

Parameters:
NUM, 2, number of inputs/weights.
WIDTH, 32, word width; Q8.24 is fixed for WIDTH=32 (FRAC=24).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
i_valid  input  1  request valid.
o_ready  output  1  block can accept a request (IDLE only).
i_k  input  NUM*WIDTH  inputs; element i at [i*WIDTH +: WIDTH].
i_w  input  NUM*WIDTH  current weights, same packing.
i_b  input  WIDTH  current bias.
i_delta  input  WIDTH  error term of this neuron.
i_lr  input  WIDTH  learning rate.
o_valid  output  1  result valid.
i_ready  input  1  downstream accepts result.
o_w  output  NUM*WIDTH  updated weights.
o_b  output  WIDTH  updated bias.
o_dk  output  NUM*WIDTH  back-propagated error per input, delta*w_i (old weights).

Behaviour:
- Reset (rst=0, async): state=IDLE, o_ready=1, o_valid=0, o_w/o_b/o_dk=0, internal regs=0. Reset asserted mid-operation aborts the update; no partial result is ever presented.
- Accept: i_valid & o_ready at a rising edge latches all inputs into internal registers; o_ready drops the next cycle. Input changes after acceptance have no effect.
- FSM states: IDLE -> SCALE -> ELEM (NUM cycles, index 0..NUM-1) -> BIAS -> DONE -> IDLE.
- SCALE: ld = fxmul(lr, delta).
- ELEM i: o_w[i] = w_i - fxmul(ld, k_i); o_dk[i] = fxmul(delta, w_i), using the old latched w_i.
- BIAS: o_b = b - ld.
- DONE: o_valid=1. o_w/o_b/o_dk stay stable while i_valid/i_ready back-pressure holds. o_valid & i_ready -> IDLE; o_valid falls and o_ready rises the next cycle. Outputs keep their last values in IDLE.
- Latency: o_valid goes high NUM+2 rising edges after the accepting edge (NUM=2: 4 edges). No overlap between requests; throughput is one sample per NUM+4 cycles minimum.
- fxmul(a,b): 64-bit signed product, arithmetic shift right 24 (truncation toward -inf), keep bits [55:24].
- Overflow on fxmul or subtraction: wraps (two's complement) unless the optional feature is enabled.
- i_valid while busy is ignored. i_ready outside DONE is ignored.

Optional Feature:
PERCEPTRON_BP_SAT_EN.
- Defined: every fxmul result and every subtraction saturates to 0x7FFFFFFF / 0x80000000 when the true value exceeds the signed 32-bit range.
- Undefined: plain two's-complement wrap; saturation logic is absent.

Test Plan:
- Basic update, NUM=2: k0=0x01000000, k1=0x02000000, w0=0x00800000, w1=0x00400000, b=0, delta=0x01000000, lr=0x00800000. Expected: o_w0=0x00000000, o_w1=0xFF400000, o_b=0xFF800000, o_dk0=0x00800000, o_dk1=0x00400000; o_valid on the 4th edge after accept.
- Overflow: delta=0x7F000000, lr=0x01000000, k0=0x02000000, w0=0. Expected o_w0=0x80000001 with PERCEPTRON_BP_SAT_EN, 0x02000000 without.
- Negative truncation: delta=0xFFFFFFFF (-2^-24), lr=0x00800000. Expected ld=0xFFFFFFFF (floor) and o_b = b+1 LSB.
- Back-pressure: hold i_ready=0 for 10 cycles in DONE. Expected: o_valid and outputs stable, o_ready=0, new i_valid ignored; after i_ready=1, o_ready=1 the next cycle.
- Reset mid-ELEM: drop rst during ELEM index 1. Expected: immediate o_valid=0, o_ready=1, outputs 0; a following request completes correctly.
- Input isolation: change i_k/i_w the cycle after accept. Expected: results match the originally latched values.
